farm_sensor_detector: RTL and testbench
=======================================

# farm_sensor_detector

Vehicle-detection front end for the farm-road approach of the highway/farm intersection. It conditions a raw inductive-loop input and counts vehicles that are waiting. It drives the single-bit `sensor` request consumed by the traffic signal controller and watches the controller's `highway_signal`/`farm_signal` lamp codes to know when the request has been served. It is the initiator side of the sensor/signal handshake and also flags unsafe lamp combinations.

## Interface
- `TICK_DIV`, default 4: clock cycles per sample tick, matching the controller's enable divider.
- `DEBOUNCE`, default 3: consecutive disagreeing sample ticks required to flip the debounced loop state.
- `CNT_W`, default 8: width of the waiting-vehicle counter.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `loop_raw`  in  1  asynchronous raw loop-detector level; 1 = vehicle present.
- `highway_signal`  in  2  controller highway lamp code.
- `farm_signal`  in  2  controller farm lamp code.
- `sensor`  out  1  request to the controller; 1 = farm traffic waiting.
- `arrival`  out  1  one-cycle pulse per debounced vehicle arrival.
- `vehicle_waiting`  out  CNT_W  count of vehicles waiting for farm green.
- `overflow`  out  1  sticky; counter saturated.
- `fault`  out  1  sticky; illegal lamp combination seen.

## Operation
- Lamp codes: 2'b01 green, 2'b10 yellow, 2'b11 red, 2'b00 dark.
- Synchronizer: two flops on `loop_raw`, both reset to 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is asserted when the count equals TICK_DIV-1.
- Debounce:
  - The debounce logic acts only on `tick`.
  - If the synced level differs from the debounced state, the agreement counter increments. When it reaches DEBOUNCE, the debounced state flips and the counter clears.
  - If the synced level equals the debounced state, the counter clears.
  - A debounced 0→1 transition produces `arrival` for exactly one cycle.
- `leave_green` = (previous-cycle farm_signal == green) && (farm_signal != green).
- Counter update, in priority order:
  1. If `leave_green`: the counter loads `arrival ? 1 : 0`.
  2. Else if `arrival` and farm_signal != green: saturating increment. Reaching or attempting past 2^CNT_W-1 sets `overflow`.
  3. Otherwise the counter holds.
  - Arrivals during farm green are passing traffic and are not counted.
- Handshake FSM with states IDLE, REQ, SERVE, FAULT:
  - IDLE → FAULT when the fault condition holds. Otherwise IDLE → REQ when `vehicle_waiting != 0`.
  - REQ → SERVE when farm_signal == green.
  - SERVE → IDLE on `leave_green`.
  - FAULT is terminal until `rst`.
  - Any state goes to FAULT when the fault condition holds. This check has the highest priority.
- `sensor` = (state == REQ), decoded from the state register.
- Fault condition: the condition is evaluated every cycle. It holds when neither lamp code is red and both are in {green, yellow}. Dark (00) on either side is ignored. When it holds, `fault` is set and stays set.

## Timing
- Reset values:
  - Outputs: all 0.
  - FSM: state IDLE.
  - Internal counters and synchronizer/debounce flops: 0.
- `rst` mid-operation discards the count, pending request and fault on the next edge.
- Arrival latency from a stable `loop_raw` rise: between 2+(DEBOUNCE-1)·TICK_DIV+1 and 2+DEBOUNCE·TICK_DIV cycles. This is 11–14 cycles at the default parameters.
- From the `arrival` cycle t:
  - `vehicle_waiting` updates at t+1.
  - `sensor` rises at t+2.
- `sensor` falls one cycle after farm_signal first reads green.
- The counter clears in the same cycle `leave_green` is detected. If `vehicle_waiting` is nonzero after that, `sensor` reasserts two cycles later.
- `sensor` is held high across any number of cycles until farm green; the controller samples it only in its highway-green state.

## Structure
- Shared package `traffic_pkg` holds:
  - Lamp-code localparams `LAMP_GREEN`, `LAMP_YELLOW`, `LAMP_RED`, `LAMP_DARK`.
  - The detector state enum `det_state_t`.
  - The same package serves the controller.
- One sub-module `loop_debouncer` contains:
  - Synchronizer, tick divider and debounce counter.
  - Parameters TICK_DIV and DEBOUNCE.
  - Outputs: debounced level and `arrival`.
- The top level holds the counter, FSM and fault check.

## Test plan
- Reset: assert `rst` with loop_raw=1 → all outputs 0 for the whole reset; arrival only after release plus the debounce latency.
- Glitch: loop_raw high for 5 cycles with farm=red → no `arrival`, vehicle_waiting=0, sensor=0.
- Single vehicle:
  - loop_raw high for 20 cycles with highway=green, farm=red → one `arrival`, vehicle_waiting=1, sensor=1 two cycles after the arrival.
  - Then farm=green → sensor=0 next cycle.
  - Then farm=yellow → vehicle_waiting=0, state IDLE.
- Saturation: CNT_W=2, four separated arrivals with farm=red → vehicle_waiting=3, overflow=1, sensor=1.
- Simultaneous: time an `arrival` in the same cycle farm goes green→yellow → vehicle_waiting=1, sensor reasserts two cycles later.
- Conflict: highway=green and farm=green for one cycle → fault=1 and sensor=0 from the next cycle until `rst`; farm=dark alone never sets fault.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/farm intersection:
// lamp codes and the farm detector handshake states.
package traffic_pkg;

    localparam logic [1:0] LAMP_DARK   = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_RED    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2,
        FAULT = 2'd3
    } det_state_t;

    // Green or yellow lets traffic move; red and dark do not.
    function automatic logic lamp_go(input logic [1:0] code);
        return (code == LAMP_GREEN) || (code == LAMP_YELLOW);
    endfunction

endpackage

// File: rtl/farm_sensor_detector_if.sv
// Sensor request and lamp-code handshake between the farm
// detector (master) and the traffic signal controller (slave).
interface farm_sensor_detector_if;

    logic       sensor;
    logic [1:0] highway_signal;
    logic [1:0] farm_signal;

    modport master (
        output sensor,
        input  highway_signal,
        input  farm_signal
    );

    modport slave (
        input  sensor,
        output highway_signal,
        output farm_signal
    );

endinterface

// File: rtl/loop_debouncer.sv
// Inductive-loop conditioning: two-flop synchronizer, sample
// tick divider and agreement counter producing a clean level.
module loop_debouncer #(
    parameter int TICK_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic loop_raw,
    output logic level,
    output logic arrival
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] AGREE_LAST = AW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [AW-1:0] agree;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            tick_cnt <= '0;
            agree    <= '0;
            level    <= 1'b0;
            arrival  <= 1'b0;
        end else begin
            sync1    <= loop_raw;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            arrival  <= 1'b0;
            if (tick) begin
                if (sync2 != level) begin
                    // DEBOUNCE disagreeing ticks in a row flip the level
                    if (agree == AGREE_LAST) begin
                        level   <= sync2;
                        agree   <= '0;
                        arrival <= sync2;
                    end else begin
                        agree <= agree + 1'b1;
                    end
                end else begin
                    agree <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/farm_sensor_detector.sv
// Farm-road vehicle detector: counts waiting vehicles, raises
// the sensor request until farm green, and latches lamp conflicts.
module farm_sensor_detector
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     loop_raw,
    farm_sensor_detector_if.master   sig,
    output logic                     arrival,
    output logic [CNT_W-1:0]         vehicle_waiting,
    output logic                     overflow,
    output logic                     fault
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

    det_state_t state;
    det_state_t state_n;
    logic       loop_level;
    logic       farm_green;
    logic       farm_green_q;
    logic       leave_green;
    logic       fault_cond;

    loop_debouncer #(
        .TICK_DIV (TICK_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .loop_raw (loop_raw),
        .level    (loop_level),
        .arrival  (arrival)
    );

    assign farm_green  = (sig.farm_signal == LAMP_GREEN);
    assign leave_green = farm_green_q && !farm_green;
    assign fault_cond  = lamp_go(sig.highway_signal)
                      && lamp_go(sig.farm_signal);
    assign sig.sensor  = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            farm_green_q    <= 1'b0;
            vehicle_waiting <= '0;
            overflow        <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state        <= state_n;
            farm_green_q <= farm_green;
            if (fault_cond) begin
                fault <= 1'b1;
            end
            // Green just ended: only a same-cycle arrival survives
            if (leave_green) begin
                vehicle_waiting <= arrival ? CNT_W'(1) : '0;
            end else if (arrival && !farm_green) begin
                if (vehicle_waiting != CNT_MAX) begin
                    vehicle_waiting <= vehicle_waiting + 1'b1;
                end
                if (vehicle_waiting >= CNT_NEAR) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (vehicle_waiting != '0) state_n = REQ;
            REQ:     if (farm_green) state_n = SERVE;
            SERVE:   if (leave_green) state_n = IDLE;
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
        if (fault_cond) begin
            state_n = FAULT;
        end
    end

endmodule

// File: tb/tb_farm_sensor_detector.sv
// Directed bench for farm_sensor_detector: reset, glitch, service,
// simultaneous clear/arrival, lamp conflict and CNT_W=2 saturation.
module tb_farm_sensor_detector;
    import traffic_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       loop_a;
    logic       loop_b;
    logic       arrival_a;
    logic [7:0] vw_a;
    logic       ovf_a;
    logic       fault_a;
    logic       arrival_b;
    logic [1:0] vw_b;
    logic       ovf_b;
    logic       fault_b;

    farm_sensor_detector_if sig_a();
    farm_sensor_detector_if sig_b();

    farm_sensor_detector dut_a (
        .clk             (clk),
        .rst             (rst),
        .loop_raw        (loop_a),
        .sig             (sig_a),
        .arrival         (arrival_a),
        .vehicle_waiting (vw_a),
        .overflow        (ovf_a),
        .fault           (fault_a)
    );

    farm_sensor_detector #(.CNT_W(2)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .loop_raw        (loop_b),
        .sig             (sig_b),
        .arrival         (arrival_b),
        .vehicle_waiting (vw_b),
        .overflow        (ovf_b),
        .fault           (fault_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_a(input logic lvl, input int n, output int arrs);
        loop_a = lvl;
        arrs = 0;
        repeat (n) begin
            step();
            if (arrival_a) arrs++;
        end
    endtask

    task automatic hold_b(input logic lvl, input int n, output int arrs);
        loop_b = lvl;
        arrs = 0;
        repeat (n) begin
            step();
            if (arrival_b) arrs++;
        end
    endtask

    initial begin
        int lat;
        int got;
        int a1;
        int a2;
        int total;

        rst    = 1'b1;
        loop_a = 1'b1;
        loop_b = 1'b0;
        sig_a.highway_signal = LAMP_GREEN;
        sig_a.farm_signal    = LAMP_RED;
        sig_b.highway_signal = LAMP_GREEN;
        sig_b.farm_signal    = LAMP_RED;

        // reset held with loop high: everything stays quiet
        for (int i = 0; i < 4; i++) begin
            step();
            check("reset_outputs",
                  {arrival_a, ovf_a, fault_a, sig_a.sensor, vw_a}, 0);
        end

        // first arrival after release within 11..14 cycles
        rst = 1'b0;
        lat = 0;
        got = 0;
        while (got == 0 && lat < 30) begin
            step();
            lat++;
            if (arrival_a) got = 1;
        end
        check("arrival_seen", got, 1);
        check("arrival_latency_in_window", (lat >= 11 && lat <= 14), 1);
        check("count_before_update", vw_a, 0);
        step();
        check("arrival_one_cycle", arrival_a, 0);
        check("count_t_plus_1", vw_a, 1);
        check("sensor_low_t_plus_1", sig_a.sensor, 0);
        step();
        check("sensor_high_t_plus_2", sig_a.sensor, 1);

        hold_a(1'b0, 20, a1);
        check("no_arrival_on_fall", a1, 0);
        check("sensor_held", sig_a.sensor, 1);

        // serve: farm green drops the request, yellow clears count
        sig_a.highway_signal = LAMP_RED;
        step();
        sig_a.farm_signal = LAMP_GREEN;
        step();
        check("sensor_drop_on_green", sig_a.sensor, 0);
        check("count_kept_in_green", vw_a, 1);
        step();
        sig_a.farm_signal = LAMP_YELLOW;
        step();
        check("count_cleared_leave_green", vw_a, 0);
        check("state_idle_after_serve", dut_a.state, IDLE);
        sig_a.farm_signal = LAMP_RED;
        step();
        sig_a.highway_signal = LAMP_GREEN;
        step();
        check("sensor_low_after_serve", sig_a.sensor, 0);

        // 5-cycle glitch never debounces
        hold_a(1'b1, 5, a1);
        hold_a(1'b0, 30, a2);
        check("glitch_no_arrival", a1 + a2, 0);
        check("glitch_count", vw_a, 0);
        check("glitch_sensor", sig_a.sensor, 0);

        // single vehicle, 20 cycles on the loop
        hold_a(1'b1, 20, a1);
        check("single_arrivals", a1, 1);
        check("single_count", vw_a, 1);
        check("single_sensor", sig_a.sensor, 1);
        hold_a(1'b0, 20, a2);
        check("single_no_extra", a2, 0);

        // arrival in the same cycle farm goes green->yellow
        sig_a.highway_signal = LAMP_RED;
        step();
        sig_a.farm_signal = LAMP_GREEN;
        step();
        check("simul_served", sig_a.sensor, 0);
        loop_a = 1'b1;
        lat = 0;
        got = 0;
        while (got == 0 && lat < 30) begin
            step();
            lat++;
            if (arrival_a) begin
                got = 1;
                sig_a.farm_signal = LAMP_YELLOW;
            end
        end
        check("simul_arrival_seen", got, 1);
        step();
        check("simul_count_one", vw_a, 1);
        check("simul_sensor_low", sig_a.sensor, 0);
        step();
        check("simul_sensor_reassert", sig_a.sensor, 1);
        sig_a.farm_signal = LAMP_RED;
        hold_a(1'b0, 20, a1);
        check("simul_pending", sig_a.sensor, 1);

        // dark farm lamp beside highway green is not a conflict
        sig_a.highway_signal = LAMP_GREEN;
        sig_a.farm_signal    = LAMP_DARK;
        repeat (4) step();
        check("dark_no_fault", fault_a, 0);
        check("dark_sensor_kept", sig_a.sensor, 1);

        // one cycle of green/green conflict
        sig_a.farm_signal = LAMP_GREEN;
        step();
        sig_a.farm_signal = LAMP_RED;
        check("conflict_fault", fault_a, 1);
        check("conflict_sensor", sig_a.sensor, 0);
        repeat (5) step();
        check("fault_sticky", fault_a, 1);
        check("fault_sensor_low", sig_a.sensor, 0);
        check("fault_state", dut_a.state, FAULT);

        // reset mid-operation clears the fault
        rst = 1'b1;
        step();
        check("mid_reset_clear",
              {ovf_a, fault_a, sig_a.sensor, vw_a}, 0);
        check("mid_reset_state", dut_a.state, IDLE);
        rst = 1'b0;
        step();

        // CNT_W=2 saturation: four vehicles, counter sticks at 3
        total = 0;
        for (int k = 0; k < 4; k++) begin
            hold_b(1'b1, 20, a1);
            hold_b(1'b0, 20, a2);
            total += a1 + a2;
            if (k == 1) begin
                check("sat_count_two", vw_b, 2);
                check("sat_no_overflow_yet", ovf_b, 0);
            end
        end
        check("sat_arrivals", total, 4);
        check("sat_count", vw_b, 3);
        check("sat_overflow", ovf_b, 1);
        check("sat_sensor", sig_b.sensor, 1);
        check("sat_no_fault", fault_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
